// File: rtl/pwm_meter_if.sv
// Result port of the PWM meter: one measurement at a time on a valid/ready handshake.
// The meter drives the master side; the consumer of results uses the slave side.
interface pwm_meter_if #(
    parameter int CNT_W = 16
) ();
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_period;
    logic [CNT_W-1:0] res_high;
    logic             res_ovf;

    modport master (
        output res_valid,
        output res_period,
        output res_high,
        output res_ovf,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_period,
        input  res_high,
        input  res_ovf,
        output res_ready
    );
endinterface

// File: rtl/pwm_meter.sv
// Loop-back meter for the PWM generator output: measures the period and high time
// in clk cycles between consecutive rising edges, with a saturation timeout for stuck inputs.
module pwm_meter #(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_in,
    input  logic       meas_en,
    pwm_meter_if.master res,
    output logic       lost
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic             sync1_q, s_q, s_dly_q;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             ovf_q, ovf_d;
    logic             lost_q, lost_d;
    logic             rise;
    logic             emit;
    logic             emit_ovf;

    assign rise = s_q & ~s_dly_q;

    // Measurement FSM and counters.
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        hcnt_d   = hcnt_q;
        emit     = 1'b0;
        emit_ovf = 1'b0;

        unique case (state_q)
            IDLE: begin
                pcnt_d = '0;
                hcnt_d = '0;
                state_d = ARM;
            end
            ARM: begin
                if (rise) begin
                    state_d = MEAS;
                    pcnt_d  = CNT_ONE;
                    hcnt_d  = CNT_ONE;
                end
            end
            MEAS: begin
                if (rise) begin
                    emit   = 1'b1;
                    pcnt_d = CNT_ONE;
                    hcnt_d = CNT_ONE;
                end else if (pcnt_q == CNT_MAX) begin
                    // A rise on the saturating cycle is handled above, so it never reports ovf.
                    emit     = 1'b1;
                    emit_ovf = 1'b1;
                    state_d  = ARM;
                end else begin
                    pcnt_d = pcnt_q + CNT_ONE;
                    if (s_q && (hcnt_q != CNT_MAX)) begin
                        hcnt_d = hcnt_q + CNT_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!meas_en) begin
            state_d  = IDLE;
            pcnt_d   = '0;
            hcnt_d   = '0;
            emit     = 1'b0;
            emit_ovf = 1'b0;
        end
    end

    // Output register with accept-and-replace; a result that cannot load is dropped and flagged.
    always_comb begin
        valid_d  = valid_q;
        period_d = period_q;
        high_d   = high_q;
        ovf_d    = ovf_q;
        lost_d   = lost_q;

        if (!meas_en || (state_q == IDLE)) begin
            valid_d = 1'b0;
            lost_d  = 1'b0;
        end else if (emit) begin
            if (!valid_q || res.res_ready) begin
                valid_d  = 1'b1;
                period_d = emit_ovf ? CNT_MAX : pcnt_q;
                high_d   = hcnt_q;
                ovf_d    = emit_ovf;
            end else begin
                lost_d = 1'b1;
            end
        end else if (valid_q && res.res_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sync1_q  <= 1'b0;
            s_q      <= 1'b0;
            s_dly_q  <= 1'b0;
            pcnt_q   <= '0;
            hcnt_q   <= '0;
            valid_q  <= 1'b0;
            period_q <= '0;
            high_q   <= '0;
            ovf_q    <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= pwm_in;
            s_q      <= sync1_q;
            s_dly_q  <= s_q;
            pcnt_q   <= pcnt_d;
            hcnt_q   <= hcnt_d;
            valid_q  <= valid_d;
            period_q <= period_d;
            high_q   <= high_d;
            ovf_q    <= ovf_d;
            lost_q   <= lost_d;
        end
    end

    assign res.res_valid  = valid_q;
    assign res.res_period = period_q;
    assign res.res_high   = high_q;
    assign res.res_ovf    = ovf_q;
    assign lost           = lost_q;

endmodule

// File: tb/tb_pwm_meter.sv
// Self-checking bench for pwm_meter: a 16-bit instance for normal measurement and
// an 8-bit instance for saturation timeouts, with a waveform-level reference model.
module tb_pwm_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic pwm16, en16, lost16;
    logic pwm8, en8, lost8;

    pwm_meter_if #(.CNT_W(16)) if16 ();
    pwm_meter_if #(.CNT_W(8))  if8 ();

    pwm_meter #(.CNT_W(16)) dut16 (
        .clk     (clk),
        .rst     (rst),
        .pwm_in  (pwm16),
        .meas_en (en16),
        .res     (if16.master),
        .lost    (lost16)
    );

    pwm_meter #(.CNT_W(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .pwm_in  (pwm8),
        .meas_en (en8),
        .res     (if8.master),
        .lost    (lost8)
    );

    typedef struct {
        int period;
        int high;
        int ovf;
        int cyc;
    } res_t;

    typedef struct {
        int p;
        int h;
        int n;
        int exp_p;
        int exp_h;
    } vec_t;

    typedef struct {
        int p;
        int h;
    } wave_t;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    res_t got16[$];
    res_t got8[$];
    res_t r16, r8;

    always @(posedge clk) cyc <= cyc + 1;

    // Every accepted transfer is logged, sampled half a cycle away from the active edge.
    always @(negedge clk) begin
        if (if16.res_valid === 1'b1 && if16.res_ready === 1'b1) begin
            r16.period = int'(if16.res_period);
            r16.high   = int'(if16.res_high);
            r16.ovf    = int'(if16.res_ovf);
            r16.cyc    = cyc;
            got16.push_back(r16);
        end
        if (if8.res_valid === 1'b1 && if8.res_ready === 1'b1) begin
            r8.period = int'(if8.res_period);
            r8.high   = int'(if8.res_high);
            r8.ovf    = int'(if8.res_ovf);
            r8.cyc    = cyc;
            got8.push_back(r8);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pwm(input bit sel8, input logic v);
        if (sel8) pwm8 = v;
        else      pwm16 = v;
    endtask

    task automatic drive(input bit sel8, input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            set_pwm(sel8, 1'b1);
            repeat (h) tick();
            set_pwm(sel8, 1'b0);
            repeat (p - h) tick();
        end
    endtask

    // Closing rise that completes the last driven period, then let the pipeline drain.
    task automatic final_rise(input bit sel8);
        set_pwm(sel8, 1'b1);
        repeat (6) tick();
    endtask

    task automatic check_results(input string name, input bit sel8, input int exp_n,
                                 input int exp_p, input int exp_h, input int exp_ovf);
        res_t q[$];
        if (sel8) q = got8;
        else      q = got16;
        check({name, "_count"}, q.size(), exp_n);
        for (int i = 0; i < q.size(); i++) begin
            check($sformatf("%s_period[%0d]", name, i), q[i].period, exp_p);
            check($sformatf("%s_high[%0d]", name, i), q[i].high, exp_h);
            check($sformatf("%s_ovf[%0d]", name, i), q[i].ovf, exp_ovf);
        end
    endtask

    task automatic restart16();
        en16 = 1'b0;
        pwm16 = 1'b0;
        repeat (3) tick();
        en16 = 1'b1;
        repeat (5) tick();
        got16.delete();
    endtask

    task automatic restart8();
        en8 = 1'b0;
        pwm8 = 1'b0;
        repeat (3) tick();
        en8 = 1'b1;
        repeat (5) tick();
        got8.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not end within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl[6];
        wave_t exp_q[$];
        int    t_rise, lat, p, h;

        tbl[0] = '{p: 100, h: 25, n: 4, exp_p: 100, exp_h: 25};
        tbl[1] = '{p: 40,  h: 10, n: 4, exp_p: 40,  exp_h: 10};
        tbl[2] = '{p: 60,  h: 30, n: 3, exp_p: 60,  exp_h: 30};
        tbl[3] = '{p: 2,   h: 1,  n: 5, exp_p: 2,   exp_h: 1};
        tbl[4] = '{p: 3,   h: 2,  n: 5, exp_p: 3,   exp_h: 2};
        tbl[5] = '{p: 9,   h: 8,  n: 4, exp_p: 9,   exp_h: 8};

        rst = 1'b1;
        pwm16 = 1'b0;
        en16 = 1'b0;
        pwm8 = 1'b0;
        en8 = 1'b0;
        if16.res_ready = 1'b1;
        if8.res_ready = 1'b1;
        repeat (3) tick();

        check("rst_valid", if16.res_valid, 0);
        check("rst_period", if16.res_period, 0);
        check("rst_high", if16.res_high, 0);
        check("rst_ovf", if16.res_ovf, 0);
        check("rst_lost", lost16, 0);
        check("rst_valid8", if8.res_valid, 0);
        rst = 1'b0;
        tick();

        // Directed waveforms on the 16-bit meter, ready always high.
        foreach (tbl[i]) begin
            restart16();
            drive(0, tbl[i].p, tbl[i].h, tbl[i].n);
            final_rise(0);
            check_results($sformatf("tbl%0d", i), 0, tbl[i].n, tbl[i].exp_p, tbl[i].exp_h, 0);
        end

        // Arming mid-high-phase: the partial period is ignored.
        en16 = 1'b0;
        pwm16 = 1'b1;
        repeat (5) tick();
        got16.delete();
        en16 = 1'b1;
        repeat (5) tick();
        pwm16 = 1'b0;
        repeat (30) tick();
        t_rise = cyc;
        drive(0, 40, 10, 3);
        final_rise(0);
        check_results("arm", 0, 3, 40, 10, 0);
        lat = (got16.size() > 0) ? got16[0].cyc - t_rise : -1;
        check("arm_latency_in_43_45", (lat >= 43 && lat <= 45), 1);

        // Stuck high on the 8-bit meter, then re-arm.
        restart8();
        pwm8 = 1'b1;
        repeat (300) tick();
        check_results("stuck_hi", 1, 1, 255, 255, 1);
        got8.delete();
        pwm8 = 1'b0;
        repeat (5) tick();
        drive(1, 50, 20, 3);
        final_rise(1);
        check_results("rearm_hi", 1, 3, 50, 20, 0);

        // Stuck low after a single-cycle high pulse, then re-arm.
        restart8();
        pwm8 = 1'b1;
        tick();
        pwm8 = 1'b0;
        repeat (300) tick();
        check_results("stuck_lo", 1, 1, 255, 1, 1);
        got8.delete();
        drive(1, 30, 10, 2);
        final_rise(1);
        check_results("rearm_lo", 1, 2, 30, 10, 0);

        // Period exactly at saturation: rise wins, no ovf.
        restart8();
        drive(1, 255, 100, 2);
        final_rise(1);
        check_results("sat_edge", 1, 2, 255, 100, 0);

        // One cycle longer times out.
        restart8();
        drive(1, 256, 100, 1);
        final_rise(1);
        check_results("sat_over", 1, 1, 255, 100, 1);

        // Back-pressure: the first result is held, later ones dropped.
        restart16();
        if16.res_ready = 1'b0;
        drive(0, 20, 5, 1);
        drive(0, 30, 9, 3);
        final_rise(0);
        check("bp_valid", if16.res_valid, 1);
        check("bp_period_held", if16.res_period, 20);
        check("bp_high_held", if16.res_high, 5);
        check("bp_ovf", if16.res_ovf, 0);
        check("bp_lost", lost16, 1);
        check("bp_no_accept", got16.size(), 0);
        if16.res_ready = 1'b1;
        tick();
        check("bp_valid_after_accept", if16.res_valid, 0);
        check("bp_lost_sticky", lost16, 1);
        check_results("bp_accept", 0, 1, 20, 5, 0);
        en16 = 1'b0;
        tick();
        check("bp_lost_clear", lost16, 0);

        // Disable mid-period with a pending result.
        restart16();
        if16.res_ready = 1'b0;
        drive(0, 60, 30, 2);
        pwm16 = 1'b1;
        repeat (10) tick();
        check("dis_pre_valid", if16.res_valid, 1);
        check("dis_pre_lost", lost16, 1);
        en16 = 1'b0;
        tick();
        check("dis_valid", if16.res_valid, 0);
        check("dis_lost", lost16, 0);
        if16.res_ready = 1'b1;
        pwm16 = 1'b0;
        repeat (5) tick();
        got16.delete();
        en16 = 1'b1;
        repeat (3) tick();
        drive(0, 60, 30, 3);
        final_rise(0);
        check_results("dis_reen", 0, 3, 60, 30, 0);

        // Reset pulse mid-operation.
        restart16();
        if16.res_ready = 1'b0;
        drive(0, 60, 30, 2);
        pwm16 = 1'b1;
        repeat (10) tick();
        check("rst_pre_lost", lost16, 1);
        pwm16 = 1'b0;
        rst = 1'b1;
        tick();
        check("mid_rst_valid", if16.res_valid, 0);
        check("mid_rst_period", if16.res_period, 0);
        check("mid_rst_high", if16.res_high, 0);
        check("mid_rst_ovf", if16.res_ovf, 0);
        check("mid_rst_lost", lost16, 0);
        rst = 1'b0;
        if16.res_ready = 1'b1;
        got16.delete();
        repeat (3) tick();
        drive(0, 60, 30, 2);
        final_rise(0);
        check_results("rst_reen", 0, 2, 60, 30, 0);

        // Random waveforms plus a duty sweep, scored against the driven waveform list.
        restart16();
        for (int i = 0; i < 40; i++) begin
            p = int'($urandom_range(400, 2));
            h = int'($urandom_range(p - 1, 1));
            drive(0, p, h, 1);
            exp_q.push_back('{p: p, h: h});
        end
        for (int k = 1; k < 16; k++) begin
            drive(0, 256, 16 * k, 1);
            exp_q.push_back('{p: 256, h: 16 * k});
        end
        final_rise(0);
        check("rand_count", got16.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got16.size(); i++) begin
            check($sformatf("rand_period[%0d]", i), got16[i].period, exp_q[i].p);
            check($sformatf("rand_high[%0d]", i), got16[i].high, exp_q[i].h);
            check($sformatf("rand_ovf[%0d]", i), got16[i].ovf, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
